lut_pipe_elastic: RTL and testbench

LUT_PIPE_ELASTIC -- requirements
Module: lut_pipe_elastic

---
 rtl/lut_pipe_elastic.sv | 81 ++++++++
 tb/tb_lut_pipe_elastic.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_pipe_elastic.sv
// Elastic register pipeline with per-stage valid bits, bubble collapse,
// synchronous flush and an occupancy counter tracking the number of valid stages.
module lut_pipe_elastic #(
  parameter int DataWidth = 112,
  parameter int Stages    = 2,
  parameter int CntWidth  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [DataWidth-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CntWidth-1:0]  occupancy
);

  logic [DataWidth-1:0] data_q [Stages];
  logic [Stages-1:0]    v_q;
  logic [Stages-1:0]    r;
  logic [CntWidth-1:0]  occ_q;
  logic                 in_acc;
  logic                 out_acc;

  // A stage may load when it, or any stage downstream of it, is empty, or the
  // sink is taking the last word. This is the backward ready chain unrolled,
  // so no bit of r depends on another bit of r.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r = '0;
    for (int k = 0; k < Stages; k++) begin
      r[k] = out_ready | (|(~v_q & ({Stages{1'b1}} << k)));
    end
  end

  assign in_ready  = r[0] & ~flush;
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = v_q[Stages-1] & out_ready;
  assign data_out  = data_q[Stages-1];
  assign out_valid = v_q[Stages-1];
  assign occupancy = occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well, so data_out reads 0 straight out of reset.
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < Stages; k++) begin
        data_q[k] <= '0;
      end
    end else if (flush) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value.
      if (r[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= data_in;
        end
      end
      for (int k = 1; k < Stages; k++) begin
        if (r[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end
      // An empty slot in the handshake pair keeps data registers frozen above.
      case ({in_acc, out_acc})
        2'b10:   occ_q <= occ_q + CntWidth'(1);
        2'b01:   occ_q <= occ_q - CntWidth'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_pipe_elastic.sv
// Self-checking bench for lut_pipe_elastic (DataWidth=8, Stages=3): directed
// scenarios plus random traffic, with a queue scoreboard checked by a monitor.
module tb_lut_pipe_elastic;

  localparam int DW = 8;
  localparam int ST = 3;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];
  int            occ_model = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  lut_pipe_elastic #(.DataWidth(DW), .Stages(ST), .CntWidth(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and return 1 time unit after the capturing edge.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: samples mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    bit exp_in_ready;
    bit in_acc;
    bit out_acc;
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      exp_q.delete();
      occ_model = 0;
      prev_hold = 1'b0;
    end else begin
      exp_in_ready = ((occ_model < ST) || out_ready) && !flush;
      check("occupancy", 32'(occupancy), 32'(occ_model));
      check("in_ready", 32'(in_ready), 32'(exp_in_ready));
      if (occ_model == 0) check("out_valid_empty", 32'(out_valid), 32'd0);
      if (occ_model == ST) check("out_valid_full", 32'(out_valid), 32'd1);
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      out_acc = out_valid && out_ready;
      in_acc  = in_valid && exp_in_ready;
      if (out_acc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected no output at %0t", data_out, $time);
        end else begin
          check("scoreboard_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (flush) begin
        exp_q.delete();
        occ_model = 0;
      end else begin
        if (in_acc) exp_q.push_back(data_in);
        occ_model = occ_model + int'(in_acc) - int'(out_acc);
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_data = data_out;
    end
  end

  initial begin
    rst = 1'b1; data_in = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #3;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Streaming: first word after 3 edges, then one per cycle, occupancy steady at 3.
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, DW'(k), 1'b1, 1'b0);
      check("stream_occ", 32'(occupancy), 32'((k < ST) ? k : ST));
      if (k >= ST) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_data", 32'(data_out), 32'(k - 2));
      end else begin
        check("stream_latency", 32'(out_valid), 32'd0);
      end
    end
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    check("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: fill with out_ready low, then drain in order.
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0);
    check("bp_occ", 32'(occupancy), 32'd3);
    in_valid = 1'b1; data_in = 8'hEE; out_ready = 1'b0;
    #1 check("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("bp_hold", 32'(data_out), 32'hA1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bp_out2", 32'(data_out), 32'hA2);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bp_out3", 32'(data_out), 32'hA3);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Bubble collapse: 0x11, two idle cycles, 0x22, all with out_ready low.
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("bubble_occ", 32'(occupancy), 32'd2);
    check("bubble_in_ready", 32'(in_ready), 32'd1);
    check("bubble_head", 32'(data_out), 32'h11);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bubble_packed_valid", 32'(out_valid), 32'd1);
    check("bubble_packed_data", 32'(data_out), 32'h22);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bubble_empty", 32'(out_valid), 32'd0);

    // Flush with a full pipe while 0x55 is offered.
    cyc(1'b1, 8'h31, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    check("flush_pre_occ", 32'(occupancy), 32'd3);
    in_valid = 1'b1; data_in = 8'h55; out_ready = 1'b0; flush = 1'b1;
    #1 check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("flush_no_55", 32'(out_valid), 32'd0);
    end

    // Mid-stream asynchronous reset with two words in flight.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    check("mrst_pre_occ", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_data_out", 32'(data_out), 32'd0);
    check("mrst_occ", 32'(occupancy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("mrst_latency", 32'(out_valid), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("mrst_77_valid", 32'(out_valid), 32'd1);
    check("mrst_77_data", 32'(data_out), 32'h77);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Random stress; the monitor checks order, loss, duplication and occupancy.
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_occ", 32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
